// File: rtl/instruction_loader.sv
// Instruction loader: assembles a little-endian byte stream into 32-bit
// words and writes them to consecutive word addresses of an instruction
// memory, one write strobe per word, with start/abort session control.
module instruction_loader #(
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [MEM_ADDR_BITS:0]  word_count,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic [7:0]              in_byte,
    output logic                    in_ready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [31:0]             mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [MEM_ADDR_BITS:0]  words_loaded
);

    localparam int CW = MEM_ADDR_BITS + 1;
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] MEM_DEPTH = {1'b1, {MEM_ADDR_BITS{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   word_idx_r;
    logic [1:0]      byte_idx_r;
    logic [23:0]     word_r;        // lower three bytes of the word being assembled
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [31:0]     mem_wdata_r;
    logic            error_r;
    logic            in_ready_r;
    logic            mem_we_r;
    logic            busy_r;
    logic            done_r;

    logic            count_ok_s;
    logic            accept_s;
    logic            start_ok_s;
    logic [CW-1:0]   word_idx_inc_s;

    // Decode the session-request and handshake qualifiers.
    always_comb begin
        count_ok_s     = (word_count != CNT_ZERO) && (word_count <= MEM_DEPTH);
        start_ok_s     = start && !abort && count_ok_s;
        accept_s       = (state_r == ST_RECV) && in_valid && !abort;
        word_idx_inc_s = word_idx_r + CNT_ONE;
    end

    // Next-state logic; abort takes priority over every other transition.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    next_state_s = ST_RECV;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (abort) begin
                    next_state_s = ST_IDLE;
                end else if (accept_s && (byte_idx_r == 2'd3)) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_RECV;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    next_state_s = ST_IDLE;
                end else if (word_idx_inc_s == count_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RECV;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Status outputs registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= (next_state_s == ST_RECV);
            mem_we_r   <= (next_state_s == ST_WRITE);
            busy_r     <= (next_state_s != ST_IDLE);
            done_r     <= (next_state_s == ST_DONE);
        end
    end

    // Session datapath: count latch, byte assembly, write address/data, error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= CNT_ZERO;
            word_idx_r  <= CNT_ZERO;
            byte_idx_r  <= 2'd0;
            word_r      <= 24'd0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= 32'd0;
            error_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (count_ok_s) begin
                            count_r    <= word_count;
                            word_idx_r <= CNT_ZERO;
                            byte_idx_r <= 2'd0;
                            error_r    <= 1'b0;
                        end else begin
                            error_r    <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (abort) begin
                        // Drop any partially assembled word.
                        byte_idx_r <= 2'd0;
                    end else if (accept_s) begin
                        byte_idx_r <= byte_idx_r + 2'd1;
                        case (byte_idx_r)
                            2'd0: word_r[7:0]   <= in_byte;
                            2'd1: word_r[15:8]  <= in_byte;
                            2'd2: word_r[23:16] <= in_byte;
                            2'd3: begin
                                // Present the completed word for the write cycle.
                                mem_wdata_r <= {in_byte, word_r};
                                mem_addr_r  <= ADDR_WIDTH'({word_idx_r[MEM_ADDR_BITS-1:0], 2'b00});
                            end
                            default: word_r <= word_r;
                        endcase
                    end
                end
                ST_WRITE: begin
                    if (!abort) begin
                        word_idx_r <= word_idx_inc_s;
                    end
                end
                default: begin
                    word_idx_r <= word_idx_r;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign mem_we       = mem_we_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    // Words written this session track the write index exactly.
    assign words_loaded = word_idx_r;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: randomized byte streams are
// compared against a queue-based model of the expected memory writes.
module tb_instruction_loader;

    localparam int AW = 32;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] word_count;
    logic          abort;
    logic          in_valid;
    logic [7:0]    in_byte;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle_cnt = 0;

    logic [31:0] mon_addr_q[$];
    logic [31:0] mon_data_q[$];
    int          mon_cyc_q[$];
    int          done_cyc_q[$];
    int          ready_we_overlap = 0;

    logic [7:0]  byte_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          exp_cyc_q[$];
    logic        abort_busy;

    instruction_loader #(.ADDR_WIDTH(32), .MEM_ADDR_BITS(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
        .abort(abort), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Cycle counter used to timestamp observed events.
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Passive monitor recording memory writes and done pulses.
    always @(negedge clk) begin
        if (mem_we) begin
            mon_addr_q.push_back(mem_addr);
            mon_data_q.push_back(mem_wdata);
            mon_cyc_q.push_back(cycle_cnt);
        end
        if (done) done_cyc_q.push_back(cycle_cnt);
        if (mem_we && in_ready) ready_we_overlap = ready_we_overlap + 1;
    end

    task automatic fill_random(input int n);
        byte_q.delete();
        for (int k = 0; k < 4 * n; k++) byte_q.push_back(8'($urandom));
    endtask

    // Runs one session from byte_q; builds the expected write list as it goes.
    task automatic drive_session(input int n, input int p, input int abort_after, input bit rand_start);
        int i;
        int guard;
        logic v;
        mon_addr_q.delete(); mon_data_q.delete(); mon_cyc_q.delete(); done_cyc_q.delete();
        exp_addr_q.delete(); exp_data_q.delete(); exp_cyc_q.delete();
        abort_busy = 1'bx;
        @(negedge clk);
        start = 1'b1; word_count = CW'(n);
        @(negedge clk);
        start = 1'b0;
        i = 0; guard = 0;
        while (i < 4 * n && guard < 4000) begin
            if (abort_after >= 0 && i == abort_after) begin
                abort = 1'b1;
                in_valid = 1'($urandom_range(1));
                @(negedge clk);
                abort = 1'b0; in_valid = 1'b0;
                abort_busy = busy;
                break;
            end
            v = ($urandom_range(99) < p);
            in_valid = v;
            in_byte = v ? byte_q[i] : 8'($urandom);
            if (v && in_ready) begin
                if (i % 4 == 3) begin
                    exp_addr_q.push_back(32'((i / 4) * 4));
                    exp_data_q.push_back({byte_q[i], byte_q[i-1], byte_q[i-2], byte_q[i-3]});
                    exp_cyc_q.push_back(cycle_cnt + 1);
                end
                i++;
            end
            if (rand_start) begin
                start = 1'($urandom_range(1));
                word_count = CW'($urandom_range(127));
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0; start = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_byte = 8'd0; word_count = 7'd0;
        #12;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0h want 0", busy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0h want 0", in_ready); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %0h want 0", mem_we); end
        n_checks++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %0h want 0", error); end
        n_checks++; if (words_loaded !== 7'd0) begin n_fail++; $display("FAIL reset_words got %0d want 0", words_loaded); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %0h want 0", busy); end
    endtask

    task automatic test_single_word();
        byte_q.delete();
        byte_q.push_back(8'h13); byte_q.push_back(8'h00); byte_q.push_back(8'h00); byte_q.push_back(8'h00);
        drive_session(1, 100, -1, 1'b0);
        n_checks++; if (mon_addr_q.size() !== 1) begin n_fail++; $display("FAIL single_writes got %0d want 1", mon_addr_q.size()); end
        if (mon_addr_q.size() == 1) begin
            n_checks++; if (mon_addr_q[0] !== 32'h0) begin n_fail++; $display("FAIL single_addr got %0h want 0", mon_addr_q[0]); end
            n_checks++; if (mon_data_q[0] !== 32'h00000013) begin n_fail++; $display("FAIL single_data got %0h want 00000013", mon_data_q[0]); end
            n_checks++; if (mon_cyc_q[0] !== exp_cyc_q[0]) begin n_fail++; $display("FAIL single_latency got %0d want %0d", mon_cyc_q[0], exp_cyc_q[0]); end
        end
        n_checks++; if (done_cyc_q.size() !== 1) begin n_fail++; $display("FAIL single_done_count got %0d want 1", done_cyc_q.size()); end
        if (done_cyc_q.size() == 1 && exp_cyc_q.size() == 1) begin
            n_checks++; if (done_cyc_q[0] !== exp_cyc_q[0] + 1) begin n_fail++; $display("FAIL single_done_cycle got %0d want %0d", done_cyc_q[0], exp_cyc_q[0] + 1); end
        end
        n_checks++; if (words_loaded !== 7'd1) begin n_fail++; $display("FAIL single_words got %0d want 1", words_loaded); end
    endtask

    task automatic test_random_sessions(input int sessions);
        int n;
        int p;
        for (int s = 0; s < sessions; s++) begin
            n = (s == 0) ? 3 : $urandom_range(8, 1);
            p = (s == 0) ? 50 : $urandom_range(100, 30);
            fill_random(n);
            drive_session(n, p, -1, 1'b1);
            n_checks++; if (mon_addr_q.size() !== exp_addr_q.size()) begin n_fail++; $display("FAIL rand_writes s%0d got %0d want %0d", s, mon_addr_q.size(), exp_addr_q.size()); end
            for (int k = 0; k < mon_addr_q.size() && k < exp_addr_q.size(); k++) begin
                n_checks++; if (mon_addr_q[k] !== exp_addr_q[k]) begin n_fail++; $display("FAIL rand_addr s%0d w%0d got %0h want %0h", s, k, mon_addr_q[k], exp_addr_q[k]); end
                n_checks++; if (mon_data_q[k] !== exp_data_q[k]) begin n_fail++; $display("FAIL rand_data s%0d w%0d got %0h want %0h", s, k, mon_data_q[k], exp_data_q[k]); end
                n_checks++; if (mon_cyc_q[k] !== exp_cyc_q[k]) begin n_fail++; $display("FAIL rand_latency s%0d w%0d got %0d want %0d", s, k, mon_cyc_q[k], exp_cyc_q[k]); end
            end
            n_checks++; if (done_cyc_q.size() !== 1) begin n_fail++; $display("FAIL rand_done_count s%0d got %0d want 1", s, done_cyc_q.size()); end
            if (done_cyc_q.size() == 1 && exp_cyc_q.size() == n) begin
                n_checks++; if (done_cyc_q[0] !== exp_cyc_q[n-1] + 1) begin n_fail++; $display("FAIL rand_done_cycle s%0d got %0d want %0d", s, done_cyc_q[0], exp_cyc_q[n-1] + 1); end
            end
            n_checks++; if (words_loaded !== CW'(n)) begin n_fail++; $display("FAIL rand_words s%0d got %0d want %0d", s, words_loaded, n); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy s%0d got %0h want 0", s, busy); end
            n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rand_error s%0d got %0h want 0", s, error); end
        end
        n_checks++; if (ready_we_overlap !== 0) begin n_fail++; $display("FAIL ready_during_write got %0d want 0", ready_we_overlap); end
    endtask

    task automatic test_bad_count();
        logic [CW-1:0] bad [2];
        bad[0] = 7'd0; bad[1] = 7'd65;
        for (int b = 0; b < 2; b++) begin
            mon_addr_q.delete();
            @(negedge clk); start = 1'b1; word_count = bad[b];
            @(negedge clk); start = 1'b0;
            repeat (3) @(negedge clk);
            n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL bad_error cnt=%0d got %0h want 1", bad[b], error); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_busy cnt=%0d got %0h want 0", bad[b], busy); end
            n_checks++; if (mon_addr_q.size() !== 0) begin n_fail++; $display("FAIL bad_writes cnt=%0d got %0d want 0", bad[b], mon_addr_q.size()); end
        end
        fill_random(1);
        drive_session(1, 100, -1, 1'b0);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL bad_error_clear got %0h want 0", error); end
        n_checks++; if (mon_addr_q.size() !== 1) begin n_fail++; $display("FAIL bad_then_good_writes got %0d want 1", mon_addr_q.size()); end
    endtask

    task automatic test_full_depth();
        fill_random(64);
        drive_session(64, 100, -1, 1'b0);
        n_checks++; if (mon_addr_q.size() !== 64) begin n_fail++; $display("FAIL full_writes got %0d want 64", mon_addr_q.size()); end
        if (mon_addr_q.size() == 64) begin
            n_checks++; if (mon_addr_q[63] !== 32'hFC) begin n_fail++; $display("FAIL full_last_addr got %0h want fc", mon_addr_q[63]); end
            n_checks++; if (mon_data_q[63] !== exp_data_q[63]) begin n_fail++; $display("FAIL full_last_data got %0h want %0h", mon_data_q[63], exp_data_q[63]); end
            n_checks++; if (mon_cyc_q[63] - mon_cyc_q[0] !== 315) begin n_fail++; $display("FAIL full_period got %0d want 315", mon_cyc_q[63] - mon_cyc_q[0]); end
        end
        n_checks++; if (words_loaded !== 7'd64) begin n_fail++; $display("FAIL full_words got %0d want 64", words_loaded); end
        n_checks++; if (done_cyc_q.size() !== 1) begin n_fail++; $display("FAIL full_done got %0d want 1", done_cyc_q.size()); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); start = 1'b1; word_count = 7'd3;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_byte = 8'($urandom);
        @(negedge clk); in_byte = 8'($urandom);
        @(negedge clk); in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %0h want 0", busy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_in_ready got %0h want 0", in_ready); end
        n_checks++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL arst_mem_addr got %0h want 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL arst_mem_wdata got %0h want 0", mem_wdata); end
        n_checks++; if ({mem_we, done, error} !== 3'b000) begin n_fail++; $display("FAIL arst_flags got %0b want 000", {mem_we, done, error}); end
        n_checks++; if (words_loaded !== 7'd0) begin n_fail++; $display("FAIL arst_words got %0d want 0", words_loaded); end
        @(negedge clk); rst_n = 1'b1;
        fill_random(1);
        drive_session(1, 100, -1, 1'b0);
        n_checks++; if (mon_addr_q.size() !== 1) begin n_fail++; $display("FAIL arst_restart_writes got %0d want 1", mon_addr_q.size()); end
        if (mon_addr_q.size() == 1) begin
            n_checks++; if (mon_addr_q[0] !== 32'h0) begin n_fail++; $display("FAIL arst_restart_addr got %0h want 0", mon_addr_q[0]); end
            n_checks++; if (mon_data_q[0] !== exp_data_q[0]) begin n_fail++; $display("FAIL arst_restart_data got %0h want %0h", mon_data_q[0], exp_data_q[0]); end
        end
    endtask

    task automatic test_abort();
        fill_random(4);
        drive_session(4, 100, 6, 1'b0);
        n_checks++; if (abort_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_next got %0h want 0", abort_busy); end
        n_checks++; if (mon_addr_q.size() !== 1) begin n_fail++; $display("FAIL abort_writes got %0d want 1", mon_addr_q.size()); end
        if (mon_data_q.size() == 1) begin
            n_checks++; if (mon_data_q[0] !== exp_data_q[0]) begin n_fail++; $display("FAIL abort_data got %0h want %0h", mon_data_q[0], exp_data_q[0]); end
        end
        n_checks++; if (words_loaded !== 7'd1) begin n_fail++; $display("FAIL abort_words got %0d want 1", words_loaded); end
        n_checks++; if (done_cyc_q.size() !== 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", done_cyc_q.size()); end
    endtask

    task automatic test_abort_idle();
        @(negedge clk); abort = 1'b1; start = 1'b1; word_count = 7'd5;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_busy got %0h want 0", busy); end
        word_count = 7'd0;
        @(negedge clk);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL abort_idle_error got %0h want 0", error); end
        n_checks++; if (words_loaded !== 7'd1) begin n_fail++; $display("FAIL abort_idle_words got %0d want 1", words_loaded); end
        abort = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_random_sessions(6);
        test_bad_count();
        test_full_depth();
        test_async_reset();
        test_abort();
        test_abort_idle();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
